// File: rtl/user_cl_aes_multilane_pkg.sv
// Shared types and lane field geometry for the multilane AES FIFO wrapper.
package cl_aes_pkg;
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int LANE_IN_W  = 16;
    localparam int LANE_OUT_W = 8;
    localparam int SEQ_W      = 8;
endpackage

// File: rtl/aes_8_bit.sv
// Byte-wide AES core model: d_out = d_in ^ key after LATENCY cycles, one byte per cycle.
module aes_8_bit #(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] d_in,
    input  logic [7:0] key,
    output logic [7:0] d_out
);
    logic [LATENCY-1:0][7:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= d_in ^ key;
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign d_out = pipe[LATENCY-1];
endmodule

// File: rtl/user_cl_aes_multilane_fifo.sv
// Synchronous result FIFO; pointers wrap naturally at the power-of-2 depth.
module aes_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [WIDTH-1:0] last_head;
    logic             do_wr, do_rd;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clock) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) begin
                rptr      <= rptr + 1'b1;
                last_head <= mem[rptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty FIFO presents the last popped word so the output never shows stale slots.
    assign rd_data = empty ? last_head : mem[rptr];
endmodule

// File: rtl/user_cl_aes_multilane.sv
// FIFO-to-FIFO AES wrapper: LANES byte cores, valid-pipe tagging, credit-checked result FIFO, flush/drain.
module user_cl_aes_multilane
    import cl_aes_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 2,
    parameter int AES_LATENCY = 4,
    parameter int OUT_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  data_empty,
    output logic                  data_rd,
    input  logic [DATA_WIDTH-1:0] data_din,
    input  logic                  data_full,
    output logic                  data_wr,
    output logic [DATA_WIDTH-1:0] data_dout,
    input  logic                  flush,
    output logic                  flush_done,
    output logic [31:0]           words_in,
    output logic [31:0]           words_out
);
    localparam int STAGES = AES_LATENCY;
    localparam int IFW    = $clog2(STAGES + 2);
    localparam int CW     = $clog2(OUT_DEPTH) + 1;

    state_e                              state;
    logic [STAGES:0]                     vld_pipe;
    logic [STAGES:0][SEQ_W-1:0]          seq_pipe;
    logic [SEQ_W-1:0]                    seq_cnt;
    logic [LANES-1:0][7:0]               lane_din, lane_key, lane_dout;
    logic [IFW-1:0]                      in_flight;
    logic [31:0]                         credit_used;
    logic [DATA_WIDTH-1:0]               res_word;
    logic [CW-1:0]                       res_count;
    logic                                res_full, res_empty;
    logic                                core_rst;

    assign core_rst = ~reset_n;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i <= STAGES; i++) in_flight = in_flight + IFW'(vld_pipe[i]);
    end

    // Credit covers words still in the cores, so the result FIFO can never overflow.
    assign credit_used = 32'(in_flight) + 32'(res_count);
    assign data_rd = reset_n && (state == RUN) && !data_empty && !res_full
                     && (credit_used < 32'(OUT_DEPTH));
    assign data_wr = reset_n && !res_empty && !data_full;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lane_din <= '0;
            lane_key <= '0;
        end else if (data_rd) begin
            for (int i = 0; i < LANES; i++) begin
                lane_din[i] <= data_din[i*LANE_IN_W +: 8];
                lane_key[i] <= data_din[i*LANE_IN_W+8 +: 8];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_8_bit #(.LATENCY(AES_LATENCY)) u_core (
            .clk   (clock),
            .rst   (core_rst),
            .d_in  (lane_din[g]),
            .key   (lane_key[g]),
            .d_out (lane_dout[g])
        );
    end

    always_comb begin
        res_word = '0;
        for (int i = 0; i < LANES; i++) res_word[i*LANE_OUT_W +: LANE_OUT_W] = lane_dout[i];
        res_word[DATA_WIDTH-1 -: SEQ_W] = seq_pipe[STAGES];
    end

    aes_result_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(DATA_WIDTH)) u_res_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (vld_pipe[STAGES]),
        .wr_data (res_word),
        .rd_en   (data_wr),
        .rd_data (data_dout),
        .count   (res_count),
        .full    (res_full),
        .empty   (res_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_pipe   <= '0;
            seq_pipe   <= '0;
            seq_cnt    <= '0;
            words_in   <= '0;
            words_out  <= '0;
            flush_done <= 1'b0;
            state      <= RUN;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], data_rd};
            seq_pipe   <= {seq_pipe[STAGES-1:0], seq_cnt};
            flush_done <= 1'b0;
            if (data_rd) begin
                seq_cnt  <= seq_cnt + 1'b1;
                words_in <= words_in + 32'd1;
            end
            if (data_wr) words_out <= words_out + 32'd1;
            case (state)
                RUN:   if (flush) state <= DRAIN;
                DRAIN: if (in_flight == '0 && res_empty) begin
                    state      <= DONE;
                    flush_done <= 1'b1;
                end
                DONE:  if (!flush) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_user_cl_aes_multilane.sv
// Directed bench with a queue scoreboard of expected result words and per-cycle protocol checks.
module tb_user_cl_aes_multilane;
    localparam int DW    = 32;
    localparam int LANES = 2;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          data_empty = 1'b1;
    logic          data_full = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data_din = '0;
    logic          data_rd, data_wr, flush_done;
    logic [DW-1:0] data_dout;
    logic [31:0]   words_in, words_out;

    user_cl_aes_multilane #(.DATA_WIDTH(DW), .LANES(LANES), .AES_LATENCY(LAT), .OUT_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .data_empty (data_empty),
        .data_rd    (data_rd),
        .data_din   (data_din),
        .data_full  (data_full),
        .data_wr    (data_wr),
        .data_dout  (data_dout),
        .flush      (flush),
        .flush_done (flush_done),
        .words_in   (words_in),
        .words_out  (words_out)
    );

    always #5 clock = ~clock;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[$];
    int            push_cycles[$];
    int            pop_cycles[$];
    int            n_in = 0, n_out = 0, fd_pulses = 0;
    logic [7:0]    m_seq = '0;
    logic          rd_seen = 1'b0, flush_prev = 1'b0;
    bit            empty_toggle = 0, full_toggle = 0, full_hold = 0;
    logic [DW-1:0] last_dout = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: each lane byte is d_in ^ key, top byte is the arrival order mod 256.
    function automatic logic [DW-1:0] model_word(logic [DW-1:0] din, logic [7:0] seq);
        logic [DW-1:0] w;
        logic [7:0]    d, k;
        w = '0;
        for (int i = 0; i < LANES; i++) begin
            d = din[16*i +: 8];
            k = din[16*i+8 +: 8];
            w[8*i +: 8] = d ^ k;
        end
        w[DW-1 -: 8] = seq;
        return w;
    endfunction

    always @(negedge clock) begin
        cyc++;
        if (!reset_n) begin
            check("rd_in_reset", 64'(data_rd), 64'd0);
            check("wr_in_reset", 64'(data_wr), 64'd0);
            exp_q.delete(); push_cycles.delete(); pop_cycles.delete();
            n_in = 0; n_out = 0; m_seq = '0; fd_pulses = 0;
        end else begin
            check("words_in", 64'(words_in), 64'(n_in));
            check("words_out", 64'(words_out), 64'(n_out));
            if (exp_q.size() == 0) check("wr_nothing_pending", 64'(data_wr), 64'd0);
            if (flush_prev) check("rd_after_flush", 64'(data_rd), 64'd0);
            if (flush_done) begin
                fd_pulses++;
                check("done_drained", 64'(exp_q.size()), 64'd0);
            end
            if (data_rd) begin
                check("pop_not_empty", 64'(data_empty), 64'd0);
                exp_q.push_back(model_word(data_din, m_seq));
                m_seq++;
                n_in++;
                pop_cycles.push_back(cyc);
            end
            if (data_wr) begin
                check("push_not_full", 64'(data_full), 64'd0);
                if (exp_q.size() > 0) check("dout", 64'(data_dout), 64'(exp_q.pop_front()));
                n_out++;
                push_cycles.push_back(cyc);
                last_dout = data_dout;
            end
            check("credit", 64'(exp_q.size() <= DEPTH), 64'd1);
        end
        rd_seen    = data_rd && reset_n;
        flush_prev = flush && reset_n;
    end

    // Source FIFO and full/empty pattern, updated after the tasks' #1 writes.
    always @(posedge clock) begin
        #2;
        if (rd_seen && src.size() > 0) void'(src.pop_front());
        data_empty = (src.size() == 0) || (empty_toggle && cyc[0]);
        data_din   = (src.size() > 0) ? src[0] : '0;
        data_full  = full_toggle ? ~data_full : full_hold;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        src.delete();
        full_hold = 0; full_toggle = 0; empty_toggle = 0; flush = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_out(int n, int bound, string name);
        int k = 0;
        while (n_out < n && k < bound) begin step(); k++; end
        check(name, 64'(n_out >= n), 64'd1);
    endtask

    task automatic wait_in(int n, int bound, string name);
        int k = 0;
        while (n_in < n && k < bound) begin step(); k++; end
        check(name, 64'(n_in >= n), 64'd1);
    endtask

    initial begin
        int k;
        do_reset();
        step();
        check("reset_words_in", 64'(words_in), 64'd0);
        check("reset_words_out", 64'(words_out), 64'd0);
        check("reset_flush_done", 64'(flush_done), 64'd0);

        // Single word: latency and packing.
        src.push_back(32'h5A0F01FF);
        wait_out(1, 20, "single_timeout");
        check("single_dout", 64'(last_dout), 64'h000055FE);
        if (push_cycles.size() > 0 && pop_cycles.size() > 0)
            check("single_latency", 64'(push_cycles[0] - pop_cycles[0]), 64'(LAT + 2));
        else
            check("single_latency_seen", 64'd0, 64'd1);

        // Streaming 300 words, seq wraps.
        do_reset();
        for (int i = 0; i < 300; i++) src.push_back((i * 32'h01030507) ^ 32'h9E3779B9);
        wait_out(300, 400, "stream_timeout");
        check("stream_words_in", 64'(words_in), 64'd300);
        check("stream_words_out", 64'(words_out), 64'd300);
        check("stream_last_seq", 64'(last_dout[31:24]), 64'h2B);
        if (push_cycles.size() == 300)
            check("stream_span", 64'(push_cycles[299] - push_cycles[0]), 64'd299);
        else
            check("stream_push_count", 64'(push_cycles.size()), 64'd300);

        // Backpressure: only OUT_DEPTH words accepted while full.
        do_reset();
        full_hold = 1;
        for (int i = 0; i < 20; i++) src.push_back(32'h1000_0000 + i * 32'h0011_2233);
        repeat (30) step();
        check("bp_accepted", 64'(words_in), 64'(DEPTH));
        check("bp_rd_stalled", 64'(data_rd), 64'd0);
        check("bp_none_out", 64'(words_out), 64'd0);
        full_hold = 0;
        wait_out(20, 100, "bp_timeout");
        check("bp_all_in", 64'(words_in), 64'd20);

        // Flush with 3 words in flight.
        do_reset();
        for (int i = 0; i < 3; i++) src.push_back(32'hC0DE_0000 + i);
        wait_in(3, 20, "flush_fill_timeout");
        step();
        flush = 1'b1;
        step();
        src.push_back(32'hAAAA5555);
        src.push_back(32'h12345678);
        k = 0;
        while (fd_pulses < 1 && k < 50) begin step(); k++; end
        check("flush_done_seen", 64'(fd_pulses), 64'd1);
        check("flush_out3", 64'(words_out), 64'd3);
        check("flush_in3", 64'(words_in), 64'd3);
        repeat (5) step();
        check("flush_single_pulse", 64'(fd_pulses), 64'd1);
        flush = 1'b0;
        wait_out(5, 50, "flush_resume_timeout");
        check("flush_resume_in", 64'(words_in), 64'd5);

        // Reset mid-operation discards in-flight and queued words.
        do_reset();
        full_hold = 1;
        for (int i = 0; i < 6; i++) src.push_back(32'h0F0F_0000 + i);
        wait_in(6, 20, "midrst_fill_timeout");
        step();
        reset_n = 1'b0;
        src.delete();
        step();
        step();
        reset_n = 1'b1;
        full_hold = 0;
        step();
        check("midrst_words_in", 64'(words_in), 64'd0);
        repeat (10) step();
        check("midrst_words_out", 64'(words_out), 64'd0);
        src.push_back(32'h00001234);
        wait_out(1, 20, "midrst_next_timeout");
        check("midrst_seq0", 64'(last_dout), 64'h00000026);

        // Empty toggling and full alternating.
        do_reset();
        empty_toggle = 1;
        full_toggle = 1;
        for (int i = 0; i < 20; i++) src.push_back(32'h7700_0000 ^ (i * 32'h0101_0301));
        wait_out(20, 200, "corner_timeout");
        check("corner_words_in", 64'(words_in), 64'd20);
        empty_toggle = 0;
        full_toggle = 0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end
endmodule
